// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: master indices and the
// default burst limit.
package dmem_arbiter_pkg;

    // Master indices as stored in the "last granted" register
    localparam logic M_CPU = 1'b0;
    localparam logic M_PM  = 1'b1;

    // Default number of back-to-back grants to one master under contention
    localparam int MAX_BURST_DEFAULT = 4;

    // A zero byte-write mask marks a read access
    function automatic logic is_read(input logic [3:0] we);
        return (we == 4'h0);
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter. Master 0 is the CPU load/store path and
// master 1 is the pattern-matching peripheral. Grant is combinational from
// the requests and the registered (last, cnt) state. Read data returns one
// cycle after the grant through per-master response registers.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_we,
    output logic        m0_gnt,
    output logic [31:0] m0_rdata,
    output logic        m0_rvalid,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_we,
    output logic        m1_gnt,
    output logic [31:0] m1_rdata,
    output logic        m1_rvalid,

    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dwe,
    input  logic [31:0] drdata
);

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    logic        last_r;
    logic [3:0]  cnt_r;
    logic        gnt0_s;
    logic        gnt1_s;
    logic        rvalid0_r;
    logic        rvalid1_r;
    logic [31:0] rdata0_r;
    logic [31:0] rdata1_r;

    // Grant selection: single requester wins; on a tie the last master keeps
    // the port until its burst budget is spent, then the other takes over.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (m0_req && m1_req) begin
            if (cnt_r < BURST_LIM) begin
                gnt0_s = (last_r == M_CPU);
                gnt1_s = (last_r == M_PM);
            end else begin
                gnt0_s = (last_r != M_CPU);
                gnt1_s = (last_r != M_PM);
            end
        end else if (m0_req) begin
            gnt0_s = 1'b1;
        end else if (m1_req) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Memory-side mux; with no grant everything is forced to zero so no
    // stray write can reach the memory.
    always_comb begin
        daddr  = 32'h0000_0000;
        dwdata = 32'h0000_0000;
        dwe    = 4'h0;
        case ({gnt1_s, gnt0_s})
            2'b01: begin
                daddr  = m0_addr;
                dwdata = m0_wdata;
                dwe    = m0_we;
            end
            2'b10: begin
                daddr  = m1_addr;
                dwdata = m1_wdata;
                dwe    = m1_we;
            end
            default: begin
                daddr  = 32'h0000_0000;
                dwdata = 32'h0000_0000;
                dwe    = 4'h0;
            end
        endcase
    end

    // Arbitration state: count consecutive grants to the last master; an
    // idle cycle restarts the count so the next tie begins a fresh burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_r <= M_CPU;
            cnt_r  <= 4'd0;
        end else if (gnt0_s || gnt1_s) begin
            if (gnt1_s == last_r) begin
                if (cnt_r < BURST_LIM) begin
                    cnt_r <= cnt_r + 4'd1;
                end else begin
                    cnt_r <= cnt_r;
                end
            end else begin
                last_r <= gnt1_s;
                cnt_r  <= 4'd1;
            end
        end else begin
            cnt_r <= 4'd0;
        end
    end

    // Read response registers: capture memory data on a granted read and
    // pulse rvalid for one cycle; rdata holds until that master's next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
            rdata0_r  <= 32'h0000_0000;
            rdata1_r  <= 32'h0000_0000;
        end else begin
            rvalid0_r <= gnt0_s && is_read(m0_we);
            rvalid1_r <= gnt1_s && is_read(m1_we);
            if (gnt0_s && is_read(m0_we)) begin
                rdata0_r <= drdata;
            end else begin
                rdata0_r <= rdata0_r;
            end
            if (gnt1_s && is_read(m1_we)) begin
                rdata1_r <= drdata;
            end else begin
                rdata1_r <= rdata1_r;
            end
        end
    end

    assign m0_gnt    = gnt0_s;
    assign m1_gnt    = gnt1_s;
    assign m0_rvalid = rvalid0_r;
    assign m1_rvalid = rvalid1_r;
    assign m0_rdata  = rdata0_r;
    assign m1_rdata  = rdata1_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter. Each stimulus cycle pushes the expected
// outputs for that cycle into a queue; a monitor on the falling edge pops
// and compares whatever the DUT presents.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_we, m1_we;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] daddr, dwdata, drdata;
    logic [3:0]  dwe;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        g0;
        logic        g1;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        logic        rv0;
        logic        rv1;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    // Bench-side memory contents: one known word, everything else derived
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h0000_0204) return 32'h1234_5678;
        return a ^ 32'hA5A5_0000;
    endfunction

    assign drdata = mem_rd(daddr);

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata)
    );

    task automatic chk(input string name, input int cyc,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%08h expected=0x%08h", name, cyc, got, exp);
        end
    endtask

    // Monitor: compare the DUT outputs against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("m0_gnt",    e.cyc, {31'd0, m0_gnt},    {31'd0, e.g0});
            chk("m1_gnt",    e.cyc, {31'd0, m1_gnt},    {31'd0, e.g1});
            chk("daddr",     e.cyc, daddr,              e.addr);
            chk("dwdata",    e.cyc, dwdata,             e.wdata);
            chk("dwe",       e.cyc, {28'd0, dwe},       {28'd0, e.we});
            chk("m0_rvalid", e.cyc, {31'd0, m0_rvalid}, {31'd0, e.rv0});
            chk("m1_rvalid", e.cyc, {31'd0, m1_rvalid}, {31'd0, e.rv1});
            chk("m0_rdata",  e.cyc, m0_rdata,           e.rd0);
            chk("m1_rdata",  e.cyc, m1_rdata,           e.rd1);
        end
    end

    // Expected registered state carried from the previous cycle's vector
    logic        p_rst = 1'b1;
    logic        p_g0 = 1'b0, p_g1 = 1'b0;
    logic [3:0]  p_we0 = 4'h0, p_we1 = 4'h0;
    logic [31:0] p_a0 = 32'h0, p_a1 = 32'h0;
    logic [31:0] x_rd0 = 32'h0, x_rd1 = 32'h0;
    int          cyc_n = 0;

    // One directed cycle: drive inputs, push the hand-chosen grant result
    // and the read-return expected from the previous cycle.
    task automatic cyc(input logic rst,
                       input logic r0, input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] e0,
                       input logic r1, input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] e1,
                       input logic eg0, input logic eg1);
        exp_t e;
        reset = rst;
        m0_req = r0; m0_addr = a0; m0_wdata = d0; m0_we = e0;
        m1_req = r1; m1_addr = a1; m1_wdata = d1; m1_we = e1;
        e.g0 = eg0;
        e.g1 = eg1;
        e.addr  = eg0 ? a0 : (eg1 ? a1 : 32'h0);
        e.wdata = eg0 ? d0 : (eg1 ? d1 : 32'h0);
        e.we    = eg0 ? e0 : (eg1 ? e1 : 4'h0);
        if (p_rst) begin
            e.rv0 = 1'b0; e.rv1 = 1'b0; x_rd0 = 32'h0; x_rd1 = 32'h0;
        end else begin
            e.rv0 = p_g0 && (p_we0 == 4'h0);
            e.rv1 = p_g1 && (p_we1 == 4'h0);
            if (e.rv0) x_rd0 = mem_rd(p_a0);
            if (e.rv1) x_rd1 = mem_rd(p_a1);
        end
        e.rd0 = x_rd0;
        e.rd1 = x_rd1;
        e.cyc = cyc_n;
        exp_q.push_back(e);
        p_rst = rst; p_g0 = eg0; p_g1 = eg1;
        p_we0 = e0; p_we1 = e1; p_a0 = a0; p_a1 = a1;
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    // Both masters reading: m0 from 0x10, m1 from 0x20
    task automatic both(input logic eg0, input logic eg1);
        cyc(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 1'b1, 32'h20, 32'h0, 4'h0, eg0, eg1);
    endtask

    task automatic m0_only_rd();
        cyc(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_we = 4'h0;
        m1_req = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_we = 4'h0;
        @(posedge clk);
        #1;

        // Reset state, with m1 fields dangling to prove the mux stays closed
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h44, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);

        // Master 0 store: same-cycle grant, no rvalid afterwards
        cyc(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
        idle();

        // Master 1 load of 0x204: data in N+1, rvalid low in N+2
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h204, 32'h0, 4'h0, 1'b0, 1'b1);
        idle();
        idle();

        // Write gating: m1 mask set but no request
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h300, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0);

        // Fairness from reset: m0 x4, m1 x4, m0 x4
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) both(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) both(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) both(1'b1, 1'b0);

        // Idle clears count: m0 x3, idle, then tie gives m0 four more
        idle();
        for (int i = 0; i < 3; i++) m0_only_rd();
        idle();
        for (int i = 0; i < 4; i++) both(1'b1, 1'b0);
        both(1'b0, 1'b1);
        idle();

        // Reset mid-burst: m1 read, then reset with m1 still requesting
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h204, 32'h0, 4'h0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0);
        both(1'b1, 1'b0);
        both(1'b1, 1'b0);
        idle();
        idle();

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter that shares the single data-memory port between the CPU load/store path (master 0) and the pattern-matching peripheral's memory master (master 1). It grants one master per cycle, drives the memory's address, write-data and byte-enable lines from the granted master, and returns registered read data. It sits between the masters and the data memory. It bounds starvation with a burst limit and round-robin hand-over.

## Interface
- `MAX_BURST`, default 4: maximum consecutive grants to one master while the other is requesting. Range 1..15.
- `clk` input, 1 bit: clock; all state updates on posedge.
- `reset` input, 1 bit: synchronous, active-high.
- `m0_req` input, 1 bit: master 0 access request; held with its fields until granted.
- `m0_addr` input, 32 bits: master 0 byte address.
- `m0_wdata` input, 32 bits: master 0 write data, already lane-aligned.
- `m0_we` input, 4 bits: master 0 byte-write mask; 0 means read.
- `m0_gnt` output, 1 bit: master 0 access performed this cycle.
- `m0_rdata` output, 32 bits: read data for master 0's last granted access.
- `m0_rvalid` output, 1 bit: `m0_rdata` valid; one-cycle pulse.
- `m1_req`, `m1_addr`, `m1_wdata`, `m1_we`, `m1_gnt`, `m1_rdata`, `m1_rvalid`: identical set for master 1.
- `daddr` output, 32 bits: memory address.
- `dwdata` output, 32 bits: memory write data.
- `dwe` output, 4 bits: memory byte-write mask.
- `drdata` input, 32 bits: memory read data, combinational from `daddr`.

## Operation
- State: `last` (1 bit, master most recently granted) and `cnt` (4 bits, consecutive grants to `last`).
- Grant selection:
  - Neither master requests: no grant.
  - Only one master requests: that master is granted.
  - Both request: `last` is granted if `cnt < MAX_BURST`; otherwise the other master is granted.
- At most one of `m0_gnt` / `m1_gnt` is high in any cycle.
- Memory mux:
  - With a grant: `daddr`, `dwdata`, `dwe` equal the granted master's fields.
  - Without a grant: all three are 0, so no memory write can occur.
- State update at posedge:
  - Grant to `last`: `cnt` increments, saturating at `MAX_BURST`.
  - Grant to the other master: `last` takes that master and `cnt` = 1.
  - No grant: `cnt` = 0 and `last` is unchanged.
- Read return:
  - At the posedge of a granted cycle with `dwe == 0`, `drdata` is registered into the granted master's `rdata` and that master's `rvalid` is set for one cycle.
  - Granted writes produce no `rvalid`.
  - `mX_rdata` holds its value until the next read by that master.
- No partial-word handling here; masters supply aligned lanes and `we`.

## Timing
- Grant is combinational from `req` and registered state, so an access completes in the cycle `req && gnt` is high.
- Read-data latency: 1 cycle after grant.
- Requester rule: a master holds `req` and its fields stable until it sees `gnt`. It may drop `req` only in or after the grant cycle.
- Reset (synchronous):
  - While `reset` is high: both `gnt` low, `dwe` = 0, `daddr` = 0, `dwdata` = 0.
  - At the reset posedge: `last` = 0, `cnt` = 0, both `rvalid` = 0, both `rdata` = 0.
  - A reset asserted mid-burst discards the count. It also cancels any `rvalid` due on the following cycle.
  - First tie after reset goes to master 0.
- Simultaneous grant-and-read plus reset: reset wins; no `rvalid` pulse.

## Structure
- Shared package: master-index constants `M_CPU = 0` and `M_PM = 1`, and the `MAX_BURST` default.
- Single module, no sub-module. The 2:1 grant/mux logic and the two response registers are small enough to inline.
- Implementation target: 120–200 lines.

## Test plan
- **Master 0 store:** `m0_req` = 1, `m0_addr` = 0x100, `m0_we` = 0xF, `m0_wdata` = 0xDEADBEEF, `m1` idle. Expect same-cycle `m0_gnt` = 1, `daddr` = 0x100, `dwe` = 0xF; `m0_rvalid` stays 0.
- **Master 1 load:** `m1` read of 0x204 while memory holds 0x12345678. Expect `m1_gnt` in cycle N; `m1_rvalid` = 1 and `m1_rdata` = 0x12345678 in N+1, low in N+2.
- **Fairness under contention:** both request continuously from reset, `MAX_BURST` = 4. Expect grant sequence m0 ×4, m1 ×4, m0 ×4; never both grants high.
- **Idle clears count:** m0 granted 3 times, one idle cycle, then both request. Expect m0 granted 4 more times before m1, because `cnt` restarted from 0.
- **Reset mid-burst:** `reset` asserted in the same cycle as an m1 read grant. Expect no `m1_rvalid` the next cycle. After release, both requesting gives m0 the first grant, and `dwe` = 0 throughout reset.
- **Write gating:** `m1_we` = 0xF with `m1_req` = 0. Expect `dwe` = 0 and no grant.
